// File: rtl/goertzel_pkg.sv
// Shared constants for the Goertzel coefficient generator: angle boundaries,
// CORDIC gain and the atan(2^-i) table, all held at 62 fractional bits.
package goertzel_pkg;

    typedef logic [67:0] c62_t;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_QUAD, S_ROT, S_MAP, S_OUT} state_e;

    localparam c62_t PI_62     = 68'h0_C90F_DAA2_2168_C234;
    localparam c62_t PI_2_62   = 68'h0_6487_ED51_10B4_611A;
    localparam c62_t PI3_2_62  = 68'h1_2D97_C7F3_321D_234E;
    localparam c62_t TWO_PI_62 = 68'h1_921F_B544_42D1_8469;
    localparam c62_t K_62      = 68'h0_26DD_3B6A_10D7_9699;

    localparam int ATAN_N = 61;

    // Taylor series of atan(2^-i) evaluated at 124 fractional bits, then truncated.
    function automatic c62_t atan_q62(input int i);
        logic [127:0] acc;
        logic [127:0] term;
        int           sh;
        if (i == 0) return PI_62 >> 2;
        acc = '0;
        for (int k = 0; k < 64; k++) begin
            sh = 124 - (2 * k + 1) * i;
            if (sh >= 0) begin
                term = (128'd1 << sh) / 128'(2 * k + 1);
                if (k % 2 == 0) acc = acc + term;
                else            acc = acc - term;
            end
        end
        return c62_t'(acc >> 62);
    endfunction

    localparam c62_t ATAN_TAB [ATAN_N] = '{
        atan_q62(0),  atan_q62(1),  atan_q62(2),  atan_q62(3),  atan_q62(4),
        atan_q62(5),  atan_q62(6),  atan_q62(7),  atan_q62(8),  atan_q62(9),
        atan_q62(10), atan_q62(11), atan_q62(12), atan_q62(13), atan_q62(14),
        atan_q62(15), atan_q62(16), atan_q62(17), atan_q62(18), atan_q62(19),
        atan_q62(20), atan_q62(21), atan_q62(22), atan_q62(23), atan_q62(24),
        atan_q62(25), atan_q62(26), atan_q62(27), atan_q62(28), atan_q62(29),
        atan_q62(30), atan_q62(31), atan_q62(32), atan_q62(33), atan_q62(34),
        atan_q62(35), atan_q62(36), atan_q62(37), atan_q62(38), atan_q62(39),
        atan_q62(40), atan_q62(41), atan_q62(42), atan_q62(43), atan_q62(44),
        atan_q62(45), atan_q62(46), atan_q62(47), atan_q62(48), atan_q62(49),
        atan_q62(50), atan_q62(51), atan_q62(52), atan_q62(53), atan_q62(54),
        atan_q62(55), atan_q62(56), atan_q62(57), atan_q62(58), atan_q62(59),
        atan_q62(60)
    };

    function automatic c62_t to_q(input c62_t val62, input int fw);
        return val62 >> (62 - fw);
    endfunction

endpackage

// File: rtl/goertzel_coef_gen_rom.sv
// Combinational atan(2^-i) lookup at FW fractional bits; zero beyond the table.
module cordic_atan_rom
    import goertzel_pkg::*;
#(
    parameter int DW = 64,
    parameter int FW = 44
)(
    input  logic [5:0]    i_i,
    output logic [DW-1:0] atan_o
);

    logic [5:0] i_c;
    c62_t       val;

    always_comb begin
        i_c    = (i_i < 6'(ATAN_N)) ? i_i : 6'd0;
        val    = to_q(ATAN_TAB[i_c], FW);
        atan_o = (i_i < 6'(ATAN_N)) ? DW'(val) : '0;
    end

endmodule

// File: rtl/goertzel_coef_gen.sv
// Iterative rotation-mode CORDIC producing cos/sin/2cos per Goertzel bin,
// streamed out over valid/ready with the bin index.
module goertzel_coef_gen
    import goertzel_pkg::*;
#(
    parameter int NF   = 11,
    parameter int DW   = 64,
    parameter int FW   = 44,
    parameter int ITER = 44,
    parameter int IW   = (NF > 1) ? $clog2(NF) : 1
)(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NF*DW-1:0]     ang_i,
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IW-1:0]        out_idx,
    output logic signed [DW-1:0] cos_o,
    output logic signed [DW-1:0] sin_o,
    output logic signed [DW-1:0] alpha_o
);

    if (DW - FW < 4 || FW > 60) begin : g_bad_fmt
        $error("goertzel_coef_gen: requires DW-FW >= 4 and FW <= 60");
    end
    if (ITER < 8 || ITER > FW) begin : g_bad_iter
        $error("goertzel_coef_gen: ITER must lie in 8..FW");
    end
    if (NF < 1 || NF > 256) begin : g_bad_nf
        $error("goertzel_coef_gen: NF must lie in 1..256");
    end

    localparam logic [DW-1:0] K_Q      = DW'(to_q(K_62, FW));
    localparam logic [DW-1:0] PI_2_Q   = DW'(to_q(PI_2_62, FW));
    localparam logic [DW-1:0] PI_Q     = DW'(to_q(PI_62, FW));
    localparam logic [DW-1:0] PI3_2_Q  = DW'(to_q(PI3_2_62, FW));
    localparam logic [DW-1:0] TWO_PI_Q = DW'(to_q(TWO_PI_62, FW));

    state_e                state_q;
    logic [IW-1:0]         idx_q, oidx_q;
    logic                  busy_q, done_q, vld_q;
    logic signed [DW-1:0]  cos_q, sin_q, alpha_q;

    logic [DW-1:0]         bank_q [NF];
    logic [DW-1:0]         a_q;
    logic signed [DW-1:0]  x_q, y_q, z_q;
    logic [5:0]            it_q;
    logic [1:0]            quad_q;

    logic                  accept;
    logic [DW-1:0]         a_raw, a_norm, atan_w;
    logic [1:0]            quad_d;
    logic signed [DW-1:0]  zq_d, xs, ys, x_rot, y_rot, z_rot, c_d, s_d;
    logic                  dir;

    assign accept = (state_q == S_IDLE) && start && !done_q;

    assign a_raw  = bank_q[idx_q];
    assign a_norm = (a_raw >= TWO_PI_Q) ? a_raw - TWO_PI_Q : a_raw;

    always_comb begin
        quad_d = 2'd0;
        zq_d   = $signed(a_q);
        if (a_q >= PI3_2_Q) begin
            quad_d = 2'd3;
            zq_d   = $signed(a_q - PI3_2_Q);
        end else if (a_q >= PI_Q) begin
            quad_d = 2'd2;
            zq_d   = $signed(a_q - PI_Q);
        end else if (a_q >= PI_2_Q) begin
            quad_d = 2'd1;
            zq_d   = $signed(a_q - PI_2_Q);
        end
    end

    cordic_atan_rom #(.DW(DW), .FW(FW)) u_atan (
        .i_i    (it_q),
        .atan_o (atan_w)
    );

    // One micro-rotation; both updates read the pre-rotation x and y.
    assign xs    = x_q >>> it_q;
    assign ys    = y_q >>> it_q;
    assign dir   = ~z_q[DW-1];
    assign x_rot = dir ? x_q - ys : x_q + ys;
    assign y_rot = dir ? y_q + xs : y_q - xs;
    assign z_rot = dir ? z_q - $signed(atan_w) : z_q + $signed(atan_w);

    always_comb begin
        c_d = x_q;
        s_d = y_q;
        case (quad_q)
            2'd1:    begin c_d = -y_q; s_d = x_q;  end
            2'd2:    begin c_d = -x_q; s_d = -y_q; end
            2'd3:    begin c_d = y_q;  s_d = -x_q; end
            default: begin c_d = x_q;  s_d = y_q;  end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            oidx_q  <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            alpha_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                vld_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (accept) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                    S_LOAD: state_q <= S_QUAD;
                    S_QUAD: state_q <= S_ROT;
                    S_ROT:  if (it_q == 6'(ITER - 1)) state_q <= S_MAP;
                    S_MAP: begin
                        cos_q   <= c_d;
                        sin_q   <= s_d;
                        alpha_q <= c_d <<< 1;
                        oidx_q  <= idx_q;
                        vld_q   <= 1'b1;
                        state_q <= S_OUT;
                    end
                    S_OUT: if (out_ready) begin
                        vld_q <= 1'b0;
                        if (idx_q == IW'(NF - 1)) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_LOAD;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Angle bank and CORDIC working registers carry no reset; the FSM qualifies them.
    always_ff @(posedge clk) begin
        case (state_q)
            S_IDLE: if (accept) begin
                for (int k = 0; k < NF; k++) bank_q[k] <= ang_i[k*DW +: DW];
            end
            S_LOAD: begin
                a_q  <= a_norm;
                x_q  <= $signed(K_Q);
                y_q  <= '0;
                it_q <= '0;
            end
            S_QUAD: begin
                quad_q <= quad_d;
                z_q    <= zq_d;
            end
            S_ROT: begin
                x_q  <= x_rot;
                y_q  <= y_rot;
                z_q  <= z_rot;
                it_q <= it_q + 6'd1;
            end
            default: ;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = vld_q;
    assign out_idx   = oidx_q;
    assign cos_o     = cos_q;
    assign sin_o     = sin_q;
    assign alpha_o   = alpha_q;

endmodule

// File: tb/tb_goertzel_coef_gen.sv
// Directed bench for goertzel_coef_gen: table-driven angle sets plus
// backpressure, restart, abort, reset and narrow-format sequences.
module tb_goertzel_coef_gen;

    localparam int  NF   = 4;
    localparam int  DW   = 64;
    localparam int  FW   = 44;
    localparam int  ITER = 44;
    localparam int  IW   = 2;
    localparam real SC   = 17592186044416.0;          // 2^44
    localparam real TOL  = 1.0 / 274877906944.0;      // 2^-38
    localparam real SC32 = 16777216.0;                // 2^24
    localparam real TOL32 = 1.0 / 262144.0;           // 2^-18
    localparam real PI   = 3.14159265358979323846;
    localparam real R2   = 0.7071067811865476;
    localparam real R3   = 0.8660254037844386;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b1;
    logic [NF*DW-1:0] ang = '0;
    logic busy, done, out_valid;
    logic [IW-1:0] out_idx;
    logic signed [DW-1:0] cos_w, sin_w, alpha_w;

    logic start32 = 1'b0;
    logic [31:0] ang32 = '0;
    logic busy32, done32, vld32;
    logic [0:0] idx32;
    logic signed [31:0] cos32, sin32, alpha32;

    always #5 clk = ~clk;

    goertzel_coef_gen #(.NF(NF), .DW(DW), .FW(FW), .ITER(ITER)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .ang_i(ang),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .cos_o(cos_w), .sin_o(sin_w), .alpha_o(alpha_w)
    );

    goertzel_coef_gen #(.NF(1), .DW(32), .FW(24), .ITER(24)) u_dut32 (
        .clk(clk), .rstn(rstn), .start(start32), .abort(1'b0), .ang_i(ang32),
        .busy(busy32), .done(done32), .out_valid(vld32), .out_ready(1'b1),
        .out_idx(idx32), .cos_o(cos32), .sin_o(sin32), .alpha_o(alpha32)
    );

    typedef struct {
        real ang;
        real c;
        real s;
    } bin_t;

    bin_t tab [8];
    int   checks = 0;
    int   failures = 0;
    real  got_c [NF];
    real  got_s [NF];
    real  got_a [NF];
    int   got_i [NF];
    int   nxfer, done_cyc, vld_cyc;

    task automatic chk_real(input string nm, input real act, input real exp, input real tol);
        checks++;
        if ((act - exp) > tol || (exp - act) > tol) begin
            failures++;
            $display("FAIL %s: got %0.12f want %0.12f", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic set_angles(input int base);
        for (int k = 0; k < NF; k++) ang[k*DW +: DW] = 64'(longint'(tab[base+k].ang * SC));
    endtask

    // One start-to-done run; optional stall on a bin, restart pulse, start in done cycle.
    task automatic run_pass(input int stall_bin, input int restart_at, input bit start_on_done);
        int n, stall_n, unstable;
        bit fin;
        logic signed [DW-1:0] sc, ss, sa;
        logic [IW-1:0] si;
        nxfer = 0; done_cyc = -1; vld_cyc = -1;
        stall_n = 0; unstable = 0; fin = 1'b0;
        sc = '0; ss = '0; sa = '0; si = '0;
        for (int k = 0; k < NF; k++) begin
            got_c[k] = 99.0; got_s[k] = 99.0; got_a[k] = 99.0; got_i[k] = -1;
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); n = 1;
        while (!fin && n < 3000) begin
            start = 1'b0;
            out_ready = 1'b1;
            if (n == restart_at) begin
                start = 1'b1;
                ang = ~ang;
            end
            if (out_valid && vld_cyc < 0) vld_cyc = n;
            if (done) begin
                done_cyc = n;
                fin = 1'b1;
                if (start_on_done) start = 1'b1;
            end else if (out_valid) begin
                if (int'(out_idx) == stall_bin && stall_n < 10) begin
                    if (stall_n == 0) begin
                        sc = cos_w; ss = sin_w; sa = alpha_w; si = out_idx;
                    end else if (cos_w !== sc || sin_w !== ss || alpha_w !== sa || out_idx !== si) begin
                        unstable++;
                    end
                    stall_n++;
                    out_ready = 1'b0;
                end else begin
                    if (nxfer < NF) begin
                        got_c[nxfer] = real'(cos_w) / SC;
                        got_s[nxfer] = real'(sin_w) / SC;
                        got_a[nxfer] = real'(alpha_w) / SC;
                        got_i[nxfer] = int'(out_idx);
                    end
                    nxfer++;
                end
            end
            @(negedge clk); n++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk_int("pass_done_seen", longint'(fin), 1);
        if (start_on_done) chk_int("start_in_done_ignored_busy", longint'(busy), 0);
        if (stall_bin >= 0) begin
            chk_int("stall_outputs_stable", unstable, 0);
            chk_int("stall_cycles", stall_n, 10);
        end
    endtask

    task automatic check_pass(input int base, input string tag);
        chk_int({tag, "_xfers"}, nxfer, NF);
        for (int k = 0; k < NF; k++) begin
            chk_real($sformatf("%s_cos%0d", tag, k), got_c[k], tab[base+k].c, TOL);
            chk_real($sformatf("%s_sin%0d", tag, k), got_s[k], tab[base+k].s, TOL);
            chk_real($sformatf("%s_alpha%0d", tag, k), got_a[k], 2.0 * tab[base+k].c, 2.0 * TOL);
            chk_int($sformatf("%s_idx%0d", tag, k), got_i[k], k);
        end
    endtask

    initial begin
        int n, seen;
        tab[0] = '{0.0,              1.0,  0.0};
        tab[1] = '{PI / 2.0,         0.0,  1.0};
        tab[2] = '{PI,              -1.0,  0.0};
        tab[3] = '{1.5 * PI,         0.0, -1.0};
        tab[4] = '{PI / 6.0,         R3,   0.5};
        tab[5] = '{1.25 * PI,       -R2,  -R2};
        tab[6] = '{1.75 * PI,        R2,  -R2};
        tab[7] = '{2.0 * PI + PI / 3.0, 0.5, R3};

        repeat (3) @(negedge clk);
        chk_int("rst_busy", busy, 0);
        chk_int("rst_done", done, 0);
        chk_int("rst_valid", out_valid, 0);
        chk_int("rst_idx", out_idx, 0);
        chk_int("rst_cos", cos_w, 0);
        chk_int("rst_sin", sin_w, 0);
        chk_int("rst_alpha", alpha_w, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 2; v++) begin
            set_angles(v * NF);
            run_pass(-1, -1, 1'b0);
            check_pass(v * NF, $sformatf("set%0d", v));
            if (v == 0) begin
                chk_int("first_valid_cycle", vld_cyc, ITER + 4);
                chk_int("done_cycle", done_cyc, NF * (ITER + 4) + 1);
            end
        end

        set_angles(4);
        run_pass(1, -1, 1'b1);
        check_pass(4, "stall");

        set_angles(4);
        run_pass(-1, 60, 1'b0);
        check_pass(4, "restart");

        // Abort in the middle of bin 2's rotations.
        set_angles(0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (108) @(negedge clk);
        chk_int("abort_pre_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk_int("abort_busy", busy, 0);
        chk_int("abort_valid", out_valid, 0);
        seen = 0;
        repeat (300) begin
            if (done || out_valid || busy) seen++;
            @(negedge clk);
        end
        chk_int("abort_quiet", seen, 0);
        run_pass(-1, -1, 1'b0);
        check_pass(0, "post_abort");

        // Narrow format instance, single bin at pi/3.
        ang32 = 32'(longint'((PI / 3.0) * SC32));
        @(negedge clk); start32 = 1'b1;
        @(negedge clk); start32 = 1'b0;
        n = 1;
        while (!vld32 && n < 100) begin
            @(negedge clk); n++;
        end
        chk_int("dw32_valid_cycle", n, 28);
        chk_real("dw32_cos", real'(cos32) / SC32, 0.5, TOL32);
        chk_real("dw32_sin", real'(sin32) / SC32, R3, TOL32);
        chk_real("dw32_alpha", real'(alpha32) / SC32, 1.0, 2.0 * TOL32);
        @(negedge clk);
        chk_int("dw32_done", done32, 1);

        // Reset asserted in the middle of a run.
        set_angles(4);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (70) @(negedge clk);
        chk_int("midrst_pre_busy", busy, 1);
        rstn = 1'b0;
        #1;
        chk_int("midrst_busy", busy, 0);
        chk_int("midrst_done", done, 0);
        chk_int("midrst_valid", out_valid, 0);
        chk_int("midrst_idx", out_idx, 0);
        chk_int("midrst_cos", cos_w, 0);
        chk_int("midrst_sin", sin_w, 0);
        chk_int("midrst_alpha", alpha_w, 0);
        repeat (3) @(negedge clk);
        chk_int("midrst_hold_busy", busy, 0);
        rstn = 1'b1;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy || out_valid || done) seen++;
        end
        chk_int("midrst_idle_after", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/goertzel_coef_gen.md
# goertzel_coef_gen

Parametrised coefficient generator for the Goertzel filter bank. On a `start` pulse it captures NF bin angles and computes cos, sin and alpha = 2·cos for each bin, one at a time, using an iterative rotation-mode CORDIC (one micro-rotation per cycle). Coefficients stream out over a valid/ready handshake tagged with the bin index. The block sits between the bin-frequency configuration and the Goertzel recursion engines. It supports full-circle angles, configurable precision, backpressure, abort and restart.

## Interface
- `NF`, 11: number of bins (channels), 1..256.
- `DW`, 64: word width of angles and outputs.
- `FW`, 44: fractional bits of all words, Q(DW-FW).FW. Elaboration error if DW-FW < 4 or FW > 60.
- `ITER`, 44: CORDIC micro-rotations, 8..FW.
- `IW`, $clog2(NF) (min 1): bin index width.

Ports:
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a run. Accepted only while idle.
- `abort`, in, 1: synchronous cancel of the current run.
- `ang_i`, in, NF×DW: unsigned angles in radians, valid range [0, 4π). Sampled on accepted `start`.
- `busy`, out, 1: run in progress.
- `done`, out, 1: one-cycle pulse after the last bin handshake.
- `out_valid`, out, 1: coefficient word valid.
- `out_ready`, in, 1: consumer accepts.
- `out_idx`, out, IW: bin index of the current output.
- `cos_o`, `sin_o`, `alpha_o`, out, DW each: signed, Q(DW-FW).FW.

## Operation
- FSM states are IDLE, LOAD, QUAD, ROT, MAP, OUT.
- **IDLE:** on `start`, copy all `ang_i` into the internal angle bank, set idx=0 and `busy`=1, then go to LOAD.
- **LOAD:**
  - a = bank[idx]; if a ≥ 2π, subtract 2π once.
  - x = K (1/CORDIC gain ≈ 0.6072529350, truncated to FW bits), y = 0, i = 0.
- **QUAD:** select the quadrant q and the residual z:
  - [0, π/2): q=0, z = a.
  - [π/2, π): q=1, z = a − π/2.
  - [π, 3π/2): q=2, z = a − π.
  - [3π/2, 2π): q=3, z = a − 3π/2.
  - Each comparison is "≥" against the boundary.
- **ROT:** runs for i = 0..ITER−1.
  - If z ≥ 0: x −= y>>>i; y += x>>>i; z −= atan(2^−i).
  - Otherwise the signs are inverted.
  - Both updates use the old x and y. Arithmetic is DW-bit two's complement.
- **MAP:** convert (x, y) to (c, s) by quadrant:
  - q0: (x, y)
  - q1: (−y, x)
  - q2: (−x, −y)
  - q3: (y, −x)
  - Also alpha = c <<< 1. No saturation is needed because |alpha| ≤ 2 and DW-FW ≥ 4.
- **OUT:**
  - `out_valid` = 1. Data and `out_idx` are held stable until `out_ready`.
  - On handshake: if idx = NF−1, pulse `done`, set `busy`=0 and go to IDLE. Otherwise idx++ and go to LOAD.
- **Abort:** `abort` in any non-IDLE state goes to IDLE on the next edge, clears `out_valid`, drops `busy` and does not pulse `done`. `abort` has priority over a same-cycle handshake.
- **Start while busy:** ignored. `ang_i` may change freely once `start` is accepted.
- **Start in the done cycle:** `start` in the cycle `done` pulses is not accepted (FSM is in IDLE the following cycle).
- **Reset:** asserting `rstn` mid-run forces IDLE. All outputs return to their reset values immediately.
- **Accuracy:** with ITER = FW, |error| ≤ 2^−(FW−6) for every output. Results are truncated, not rounded.

## Timing
- Reset values: `busy`, `done`, `out_valid`, `out_idx`, `cos_o`, `sin_o`, `alpha_o` are all 0.
- `start` sampled at edge T gives LOAD at T+1, QUAD at T+2, ROT at T+3..T+2+ITER, MAP at T+3+ITER, and `out_valid` high from T+4+ITER.
- Per bin: ITER+4 cycles plus stall cycles.
- Full run with no stall: NF·(ITER+4) cycles from `start` to the last handshake. `done` is high the cycle after that handshake.
- Handshake: a transfer occurs on an edge where `out_valid` && `out_ready`. `out_valid` never drops without a transfer, except on abort or reset.

## Structure
- **Package `goertzel_pkg`** holds:
  - The constants PI, PI/2, 3PI/2, 2PI and K at 62 fractional bits.
  - A 61-entry atan(2^−i) table at 62 fractional bits.
  - A function `to_q(val62, FW)` that shifts a 62-fractional-bit constant right to FW bits.
- **Sub-module `cordic_atan_rom`:** combinational, parameter FW, input i, output the DW-bit atan(2^−i) at FW fractional bits. It returns 0 for i ≥ 61.
- The FSM, angle bank and datapath live in the top module.

## Test plan
- Default parameters, NF=4, angles {0, π/2, π, 3π/2}, `out_ready`=1:
  - (cos, sin) = (1,0), (0,1), (−1,0), (0,−1).
  - alpha = 2, 0, −2, 0.
  - Each within 2^−38; `done` at cycle 4·48+1 after `start`.
- Angles {π/6, 5π/4, 7π/4, 2π + π/3} → cos/sin match the real-valued reference within 2^−38; the last bin gives cos = 0.5, sin = 0.866025.
- Hold `out_ready` low for 10 cycles while `out_valid`=1 → `cos_o`, `sin_o`, `alpha_o` and `out_idx` stay stable; exactly NF transfers occur with indices 0..NF−1 in order.
- Assert `abort` during ROT of bin 2 → next cycle `busy`=0 and `out_valid`=0, no `done`; a new `start` produces a full correct run from idx 0.
- Pulse `start` again at bin 1 with different `ang_i` → ignored; outputs match the originally captured angles.
- Deassert `rstn` mid-run → all outputs 0 while reset is held; after release, IDLE and `busy`=0.
- DW=32, FW=24, ITER=24, NF=1, angle π/3 → cos = 0.5 within 2^−18.
